data_axi_bridge: RTL and testbench

- Single-beat AXI4 master serving the MEM stage's data request port.
- Accepts the stage's request (ce/we/addr/sel/data) and issues one AXI read or write transaction, holding `axi_busy_o` high until the response returns.
- Returns load data in the stage's lane order, so MEM extracts bytes unchanged.
- Sits between MEM and the top-level AXI crossbar, beside the instruction-side master.

---
 rtl/data_axi_bridge_pkg.sv | 32 +++
 rtl/data_axi_bridge.sv | 180 ++++++++++++++++++
 tb/tb_data_axi_bridge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_axi_bridge_pkg.sv
// Shared types and helpers for the data-side AXI master: FSM states, AXI constants, lane/size helpers.
package data_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } data_axi_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // MEM numbers bytes from the top lane down; AXI numbers them from the bottom up.
    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // One lane -> byte, two -> halfword, anything else (including none) -> word.
    function automatic logic [2:0] axi_size_from_sel(input logic [3:0] sel);
        logic [2:0] cnt;
        cnt = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
        case (cnt)
            3'd1:    return 3'd0;
            3'd2:    return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/data_axi_bridge.sv
// Single-beat AXI4 master for the MEM data port; 4 cycles request-to-DONE with a zero-wait slave, +1 per slave wait.
// Stalls MEM via axi_busy_o until DONE; AXI outputs held while valid && !ready. DATA_AXI_ERR_EN enables error reporting.
module data_axi_bridge
    import data_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic        axi_busy_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [7:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic        err_valid_o,
    output logic [31:0] err_addr_o
);

    data_axi_state_t state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            aw_pend_q, aw_pend_d;
    logic            w_pend_q, w_pend_d;
    logic            resp_err;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        resp_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_ce_i) begin
                    addr_d    = mem_addr_i;
                    sel_d     = mem_sel_i;
                    wdat_d    = mem_data_i;
                    aw_pend_d = mem_we_i;
                    w_pend_d  = mem_we_i;
                    state_d   = mem_we_i ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (arready_i) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rvalid_i) begin
                    rdat_d   = byte_swap32(rdata_i);
                    resp_err = (rresp_i != AXI_RESP_OKAY);
                    state_d  = S_DONE;
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; either may finish first or both together.
                if (aw_pend_q && awready_i) aw_pend_d = 1'b0;
                if (w_pend_q && wready_i)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (bvalid_i) begin
                    resp_err = (bresp_i != AXI_RESP_OKAY);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    // Idle only reports busy once MEM actually asks, so non-memory instructions never stall.
    assign axi_busy_o = (state_q == S_IDLE) ? mem_ce_i : (state_q != S_DONE);
    assign mem_data_o = rdat_q;

    assign arid_o    = AXI_ID;
    assign araddr_o  = {addr_q[31:2], 2'b00};
    assign arlen_o   = 8'd0;
    assign arsize_o  = axi_size_from_sel(sel_q);
    assign arburst_o = AXI_BURST_INCR;
    assign arvalid_o = (state_q == S_RD_ADDR);
    assign rready_o  = (state_q == S_RD_DATA);

    assign awid_o    = AXI_ID;
    assign awaddr_o  = {addr_q[31:2], 2'b00};
    assign awlen_o   = 8'd0;
    assign awsize_o  = axi_size_from_sel(sel_q);
    assign awburst_o = AXI_BURST_INCR;
    assign awvalid_o = (state_q == S_WR_REQ) && aw_pend_q;
    assign wdata_o   = byte_swap32(wdat_q);
    assign wstrb_o   = {sel_q[0], sel_q[1], sel_q[2], sel_q[3]};
    assign wlast_o   = 1'b1;
    assign wvalid_o  = (state_q == S_WR_REQ) && w_pend_q;
    assign bready_o  = (state_q == S_WR_RESP);

`ifdef DATA_AXI_ERR_EN
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        unused_rlast;

    // resp_err only fires on the transition into DONE, so the pulse covers exactly that cycle.
    always_comb begin
        err_valid_d = resp_err;
        err_addr_d  = resp_err ? addr_q : err_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o  = err_valid_q;
    assign err_addr_o   = err_addr_q;
    assign unused_rlast = rlast_i;
`else
    logic unused_resp;

    assign err_valid_o = 1'b0;
    assign err_addr_o  = '0;
    assign unused_resp = ^{resp_err, rlast_i, addr_q[1:0]};
`endif

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: vector table of single transactions plus stall/split/reset/error sequences.
module tb_data_axi_bridge;

    logic        clk;
    logic        rst;
    logic        mem_ce_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [3:0]  mem_sel_i;
    logic        axi_busy_o;
    logic [31:0] mem_data_o;
    logic [3:0]  arid_o, awid_o;
    logic [31:0] araddr_o, awaddr_o;
    logic [7:0]  arlen_o, awlen_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o;
    logic        arvalid_o, arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i, rvalid_i, rready_o;
    logic        awvalid_o, awready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o;
    logic        err_valid_o;
    logic [31:0] err_addr_o;

    data_axi_bridge dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .axi_busy_o(axi_busy_o), .mem_data_o(mem_data_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Observations gathered by run_txn
    logic [31:0] obs_addr, obs_wdata, obs_mdata, obs_err_a;
    logic [2:0]  obs_size;
    logic [3:0]  obs_wstrb, obs_id;
    logic [7:0]  obs_len;
    logic [1:0]  obs_burst;
    logic        obs_wlast, obs_err_v, addr_unstable, wdata_unstable;
    int          obs_busy, obs_aw_done_w_pend, w_hs_cyc, b_first_cyc;

    // Presents one request and plays a slave with per-channel wait counts; samples and drives at negedge.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input logic [31:0] rdata, input logic [1:0] resp,
                           input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w);
        int  ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0, cyc = 0;
        logic done = 1'b0, have_a = 1'b0, have_w = 1'b0;
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        rdata_i = rdata; rresp_i = resp; bresp_i = resp;
        obs_busy = 0; obs_aw_done_w_pend = 0; w_hs_cyc = -1; b_first_cyc = -1;
        addr_unstable = 1'b0; wdata_unstable = 1'b0;
        obs_addr = '0; obs_size = '0; obs_wdata = '0; obs_wstrb = '0; obs_mdata = '0;
        obs_err_v = 1'b0; obs_err_a = '0;
        while (!done && cyc < 60) begin
            arready_i = arvalid_o && (ar_n >= ar_w);
            rvalid_i  = rready_o  && (r_n  >= r_w);
            rlast_i   = rvalid_i;
            awready_i = awvalid_o && (aw_n >= aw_w);
            wready_i  = wvalid_o  && (w_n  >= w_w);
            bvalid_i  = bready_o  && (b_n  >= b_w);
            if (arvalid_o) begin
                if (have_a && araddr_o !== obs_addr) addr_unstable = 1'b1;
                obs_addr = araddr_o; obs_size = arsize_o; obs_len = arlen_o;
                obs_burst = arburst_o; obs_id = arid_o; have_a = 1'b1; ar_n++;
            end
            if (rready_o) r_n++;
            if (awvalid_o) begin
                if (have_a && awaddr_o !== obs_addr) addr_unstable = 1'b1;
                obs_addr = awaddr_o; obs_size = awsize_o; obs_len = awlen_o;
                obs_burst = awburst_o; obs_id = awid_o; have_a = 1'b1; aw_n++;
            end
            if (wvalid_o) begin
                if (have_w && wdata_o !== obs_wdata) wdata_unstable = 1'b1;
                obs_wdata = wdata_o; obs_wstrb = wstrb_o; obs_wlast = wlast_o; have_w = 1'b1;
                if (!awvalid_o) obs_aw_done_w_pend++;
                if (wready_i) w_hs_cyc = cyc;
                w_n++;
            end
            if (bready_o) begin
                if (b_first_cyc < 0) b_first_cyc = cyc;
                b_n++;
            end
            #1;
            if (axi_busy_o) obs_busy++;
            else begin
                done = 1'b1;
                obs_mdata = mem_data_o; obs_err_v = err_valid_o; obs_err_a = err_addr_o;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check("txn_timeout", 32'(cyc), 32'd0);
        // MEM advances after DONE; the bridge must now sit idle.
        mem_ce_i = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        #1;
        check("post_done_busy", {31'd0, axi_busy_o}, 32'd0);
        check("post_done_valids", {27'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 32'd0);
        check("post_done_err_pulse", {31'd0, err_valid_o}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{we:1'b0, addr:32'h1C000104, sel:4'b1111, data:32'h0, rdata:32'h11223344,
                    exp_addr:32'h1C000104, exp_size:3'd2, exp_wstrb:4'h0, exp_wdata:32'h0, exp_mdata:32'h44332211};
        vecs[1] = '{we:1'b1, addr:32'h00000003, sel:4'b0001, data:32'hABABABAB, rdata:32'h0,
                    exp_addr:32'h00000000, exp_size:3'd0, exp_wstrb:4'b1000, exp_wdata:32'hABABABAB, exp_mdata:32'h0};
        vecs[2] = '{we:1'b1, addr:32'h20000006, sel:4'b0011, data:32'h12345678, rdata:32'h0,
                    exp_addr:32'h20000004, exp_size:3'd1, exp_wstrb:4'b1100, exp_wdata:32'h78563412, exp_mdata:32'h0};
        vecs[3] = '{we:1'b1, addr:32'h00000040, sel:4'b0000, data:32'hDEADBEEF, rdata:32'h0,
                    exp_addr:32'h00000040, exp_size:3'd2, exp_wstrb:4'b0000, exp_wdata:32'hEFBEADDE, exp_mdata:32'h0};
        vecs[4] = '{we:1'b0, addr:32'h00000102, sel:4'b0100, data:32'h0, rdata:32'hA1B2C3D4,
                    exp_addr:32'h00000100, exp_size:3'd0, exp_wstrb:4'h0, exp_wdata:32'h0, exp_mdata:32'hD4C3B2A1};
        vecs[5] = '{we:1'b0, addr:32'h0000000B, sel:4'b0111, data:32'h0, rdata:32'h01020304,
                    exp_addr:32'h00000008, exp_size:3'd2, exp_wstrb:4'h0, exp_wdata:32'h0, exp_mdata:32'h04030201};

        rst = 1'b0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
        arready_i = 1'b0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; bresp_i = '0; bvalid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, axi_busy_o}, 32'd0);
        check("rst_valids", {27'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 32'd0);
        check("rst_mem_data", mem_data_o, 32'd0);
        check("rst_err_valid", {31'd0, err_valid_o}, 32'd0);
        check("rst_err_addr", err_addr_o, 32'd0);
        mem_ce_i = 1'b1;
        #1;
        check("idle_busy_follows_ce", {31'd0, axi_busy_o}, 32'd1);
        mem_ce_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, vecs[i].rdata, 2'b00, 0, 0, 0, 0, 0);
            check($sformatf("v%0d_addr", i), obs_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_size", i), {29'd0, obs_size}, {29'd0, vecs[i].exp_size});
            check($sformatf("v%0d_busy_cycles", i), 32'(obs_busy), 32'd3);
            check($sformatf("v%0d_len_burst_id", i), {18'd0, obs_len, obs_burst, obs_id}, {18'd0, 8'd0, 2'b01, 4'd1});
            if (vecs[i].we) begin
                check($sformatf("v%0d_wstrb", i), {28'd0, obs_wstrb}, {28'd0, vecs[i].exp_wstrb});
                check($sformatf("v%0d_wdata", i), obs_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_wlast", i), {31'd0, obs_wlast}, 32'd1);
            end else begin
                check($sformatf("v%0d_mem_data", i), obs_mdata, vecs[i].exp_mdata);
            end
        end

        // Store where AW completes three cycles before W
        run_txn(1'b1, 32'h00001000, 4'b1111, 32'hCAFEF00D, 32'h0, 2'b00, 0, 0, 0, 3, 0);
        check("split_w_only_cycles", 32'(obs_aw_done_w_pend), 32'd3);
        check("split_bready_after_w", 32'(b_first_cyc), 32'(w_hs_cyc + 1));
        check("split_busy_cycles", 32'(obs_busy), 32'd6);
        check("split_wdata_stable", {31'd0, wdata_unstable}, 32'd0);
        check("split_wdata", obs_wdata, 32'h0DF0FECA);

        // Read with AR waiting 2 cycles and R waiting 3
        run_txn(1'b0, 32'h30000020, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00, 2, 3, 0, 0, 0);
        check("stall_busy_cycles", 32'(obs_busy), 32'd8);
        check("stall_addr_stable", {31'd0, addr_unstable}, 32'd0);
        check("stall_addr", obs_addr, 32'h30000020);
        check("stall_mem_data", obs_mdata, 32'hEFBEADDE);

        // Error response on a store
        run_txn(1'b1, 32'h80000010, 4'b1111, 32'h55AA55AA, 32'h0, 2'b10, 0, 0, 0, 0, 1);
`ifdef DATA_AXI_ERR_EN
        check("err_pulse_in_done", {31'd0, obs_err_v}, 32'd1);
        check("err_addr_in_done", obs_err_a, 32'h80000010);
        check("err_addr_held", err_addr_o, 32'h80000010);
`else
        check("noerr_valid", {31'd0, obs_err_v}, 32'd0);
        check("noerr_addr", obs_err_a, 32'd0);
`endif
        check("err_busy_cycles", 32'(obs_busy), 32'd4);

        // Reset asserted while waiting in RD_DATA
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h00000200; mem_sel_i = 4'b1111;
        begin
            int  n = 0;
            logic seen = 1'b0;
            while (!seen && n < 20) begin
                arready_i = arvalid_o;
                rvalid_i  = 1'b0;
                if (rready_o) seen = 1'b1;
                else begin
                    @(negedge clk);
                    n++;
                end
            end
            check("rstmid_reached_rd_data", {31'd0, seen}, 32'd1);
        end
        arready_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valids", {27'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 32'd0);
        check("rstmid_busy_ce1", {31'd0, axi_busy_o}, 32'd1);
        check("rstmid_mem_data", mem_data_o, 32'd0);
        check("rstmid_err_addr", err_addr_o, 32'd0);
        mem_ce_i = 1'b0;
        #1;
        check("rstmid_busy_ce0", {31'd0, axi_busy_o}, 32'd0);
        rst = 1'b1;

        // Bridge must still work after the abandoned transaction
        run_txn(1'b0, 32'h00000300, 4'b1111, 32'h0, 32'h89ABCDEF, 2'b00, 0, 1, 0, 0, 0);
        check("after_rst_mem_data", obs_mdata, 32'hEFCDAB89);
        check("after_rst_busy_cycles", 32'(obs_busy), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
